// File: rtl/image_processor.sv
// UART-fed 3x3 smoothing filter: a received grayscale frame is filtered into
// image_ram and the result is streamed back out on tx.

module uart_rx #(
  parameter int BIT_CLKS = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  localparam int HALF = BIT_CLKS / 2;
  localparam int CW   = $clog2(BIT_CLKS + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          valid_reg, valid_next;
  logic          sync1_reg, sync2_reg, prev_reg;

  // Synchronizer and edge history reset low: a line held low across reset
  // release must be seen high before any falling edge can start a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      state_reg <= R_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    unique case (state_reg)
      R_IDLE: begin
        cnt_next = '0;
        if (prev_reg && !sync2_reg) state_next = R_START;
      end
      R_START: begin
        if (cnt_reg == CW'(HALF - 1)) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2_reg ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_reg == CW'(BIT_CLKS - 1)) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_reg == CW'(BIT_CLKS - 1)) begin
          valid_next = sync2_reg;
          state_next = R_IDLE;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  assign byte_valid = valid_reg;
  assign byte_data  = shift_reg;
endmodule

module uart_tx #(
  parameter int BIT_CLKS = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = $clog2(BIT_CLKS + 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_GAP} tx_state_t;

  tx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= T_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  // T_GAP holds the line idle one extra bit period between bytes.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    unique case (state_reg)
      T_IDLE: begin
        cnt_next = '0;
        if (start) begin
          shift_next = data;
          state_next = T_START;
        end
      end
      T_START: begin
        if (cnt_reg == CW'(BIT_CLKS - 1)) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = T_DATA;
        end
      end
      T_DATA: begin
        if (cnt_reg == CW'(BIT_CLKS - 1)) begin
          cnt_next = '0;
          bit_next = bit_reg + 1'b1;
          if (bit_reg == 3'd7) state_next = T_STOP;
          else shift_next = {1'b0, shift_reg[7:1]};
        end
      end
      T_STOP: begin
        if (cnt_reg == CW'(BIT_CLKS - 1)) begin
          cnt_next   = '0;
          state_next = T_GAP;
        end
      end
      T_GAP: begin
        if (cnt_reg == CW'(BIT_CLKS - 1)) state_next = T_IDLE;
      end
      default: state_next = T_IDLE;
    endcase
    tx_next = 1'b1;
    if (state_next == T_START) tx_next = 1'b0;
    else if (state_next == T_DATA) tx_next = shift_next[0];
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != T_IDLE);
endmodule

module dp_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] ram [DEPTH];
  logic [7:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    rdata_reg <= ram[raddr];
  end

  assign rdata = rdata_reg;
endmodule

module filter_ctrl #(
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int AW           = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  output logic          clr,
  output logic          acc_en,
  output logic [3:0]    acc_idx,
  output logic          compute_en,
  output logic          border,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          done_pulse,
  output logic          busy
);
  localparam int XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, COMPUTE = 3'd2, WRITE = 3'd3, DONE = 3'd4
  } flt_state_t;

  flt_state_t    state, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [3:0]    k_reg, k_next;
  logic [1:0]    kx, ky;
  logic          last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      x_reg <= '0;
      y_reg <= '0;
      k_reg <= '0;
    end else begin
      state <= state_next;
      x_reg <= x_next;
      y_reg <= y_next;
      k_reg <= k_next;
    end
  end

  assign border = (x_reg == '0) || (x_reg == XW'(IMAGE_WIDTH - 1)) ||
                  (y_reg == '0) || (y_reg == YW'(IMAGE_HEIGHT - 1));
  assign last   = (x_reg == XW'(IMAGE_WIDTH - 1)) && (y_reg == YW'(IMAGE_HEIGHT - 1));

  always_comb begin
    state_next = state;
    x_next     = x_reg;
    y_next     = y_reg;
    k_next     = k_reg;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = LOAD;
          x_next     = '0;
          y_next     = '0;
          k_next     = '0;
        end
      end
      LOAD: begin
        k_next = k_reg + 1'b1;
        if (k_reg == 4'd9) state_next = COMPUTE;
      end
      COMPUTE: state_next = WRITE;
      WRITE: begin
        k_next = '0;
        if (last) begin
          state_next = DONE;
        end else begin
          state_next = LOAD;
          if (x_reg == XW'(IMAGE_WIDTH - 1)) begin
            x_next = '0;
            y_next = y_reg + 1'b1;
          end else begin
            x_next = x_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Window tap k = 3*ky + kx; border pixels (and the idle tap 9) read the centre only.
  always_comb begin
    ky = 2'd1;
    kx = 2'd1;
    if (!border && k_reg < 4'd9) begin
      if (k_reg >= 4'd6) ky = 2'd2;
      else if (k_reg >= 4'd3) ky = 2'd1;
      else ky = 2'd0;
      kx = 2'(k_reg - 4'(ky) * 4'd3);
    end
  end

  assign rd_addr    = AW'((int'(y_reg) + int'(ky) - 1) * IMAGE_WIDTH + int'(x_reg) + int'(kx) - 1);
  assign wr_addr    = AW'(int'(y_reg) * IMAGE_WIDTH + int'(x_reg));
  assign clr        = (state == LOAD) && (k_reg == 4'd0);
  assign acc_en     = (state == LOAD) && (k_reg != 4'd0);
  assign acc_idx    = k_reg - 1'b1;
  assign compute_en = (state == COMPUTE);
  assign wr_en      = (state == WRITE);
  assign done_pulse = (state == WRITE) && last;
  assign busy       = (state == LOAD) || (state == COMPUTE) || (state == WRITE);
endmodule

module smooth_filter #(
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int AW           = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          done_pulse,
  output logic          busy
);
  logic        clr, acc_en, compute_en, border;
  logic [3:0]  acc_idx;
  logic [1:0]  wshift;
  logic [11:0] sum_reg;
  logic [7:0]  center_reg, result_reg;

  filter_ctrl #(
    .IMAGE_WIDTH(IMAGE_WIDTH), .IMAGE_HEIGHT(IMAGE_HEIGHT), .AW(AW)
  ) filter_controller (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .clr(clr),
    .acc_en(acc_en), .acc_idx(acc_idx), .compute_en(compute_en), .border(border),
    .wr_en(wr_en), .wr_addr(wr_addr), .done_pulse(done_pulse), .busy(busy)
  );

  // Kernel [1 2 1; 2 4 2; 1 2 1]: centre tap x4, odd taps (edges) x2, corners x1.
  assign wshift = (acc_idx == 4'd4) ? 2'd2 : (acc_idx[0] ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg    <= '0;
      center_reg <= '0;
      result_reg <= '0;
    end else begin
      if (clr) sum_reg <= '0;
      else if (acc_en) sum_reg <= sum_reg + (12'(rd_data) << wshift);
      if (acc_en && acc_idx == 4'd4) center_reg <= rd_data;
      if (compute_en) result_reg <= border ? center_reg : sum_reg[11:4];
    end
  end

  assign wr_data = result_reg;
endmodule

module image_processor #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int N        = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW       = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND, ST_WAIT} st_state_t;

  logic          byte_valid, capture, start_reg;
  logic [7:0]    byte_data, in_rdata, img_rdata, flt_wr_data;
  logic [AW-1:0] pix_cnt_reg, flt_rd_addr, flt_wr_addr;
  logic          flt_wr_en, flt_done, flt_busy;
  st_state_t     st_reg, st_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          tx_start, tx_busy, stream_busy;

  uart_rx #(.BIT_CLKS(BIT_CLKS)) u_rx (
    .clk(clk), .rst(rst), .rx(rx), .byte_valid(byte_valid), .byte_data(byte_data)
  );

  // Bytes are dropped while filtering, streaming, or on the start-pulse cycle.
  assign capture = byte_valid && !flt_busy && !stream_busy && !start_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_reg <= '0;
      start_reg   <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      if (capture) begin
        if (pix_cnt_reg == AW'(N - 1)) begin
          pix_cnt_reg <= '0;
          start_reg   <= 1'b1;
        end else begin
          pix_cnt_reg <= pix_cnt_reg + 1'b1;
        end
      end
    end
  end

  dp_ram #(.DEPTH(N), .AW(AW)) input_buf (
    .clk(clk), .we(capture), .waddr(pix_cnt_reg), .wdata(byte_data),
    .raddr(flt_rd_addr), .rdata(in_rdata)
  );

  smooth_filter #(
    .IMAGE_WIDTH(IMAGE_WIDTH), .IMAGE_HEIGHT(IMAGE_HEIGHT), .AW(AW)
  ) filter (
    .clk(clk), .rst(rst), .start(start_reg), .rd_addr(flt_rd_addr), .rd_data(in_rdata),
    .wr_en(flt_wr_en), .wr_addr(flt_wr_addr), .wr_data(flt_wr_data),
    .done_pulse(flt_done), .busy(flt_busy)
  );

  dp_ram #(.DEPTH(N), .AW(AW)) image_ram (
    .clk(clk), .we(flt_wr_en), .waddr(flt_wr_addr), .wdata(flt_wr_data),
    .raddr(idx_reg), .rdata(img_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_reg  <= ST_IDLE;
      idx_reg <= '0;
    end else begin
      st_reg  <= st_next;
      idx_reg <= idx_next;
    end
  end

  // ST_FETCH covers the one-cycle read latency of image_ram.
  always_comb begin
    st_next  = st_reg;
    idx_next = idx_reg;
    tx_start = 1'b0;
    unique case (st_reg)
      ST_IDLE: begin
        if (flt_done) begin
          idx_next = '0;
          st_next  = ST_FETCH;
        end
      end
      ST_FETCH: st_next = ST_SEND;
      ST_SEND: begin
        tx_start = 1'b1;
        st_next  = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_busy) begin
          if (idx_reg == AW'(N - 1)) begin
            st_next = ST_IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
            st_next  = ST_FETCH;
          end
        end
      end
      default: st_next = ST_IDLE;
    endcase
  end

  assign stream_busy = (st_reg != ST_IDLE);

  uart_tx #(.BIT_CLKS(BIT_CLKS)) u_tx (
    .clk(clk), .rst(rst), .start(tx_start), .data(img_rdata), .tx(tx), .busy(tx_busy)
  );
endmodule

// File: tb/tb_image_processor.sv
// Directed bench for image_processor: drives frames on rx, pushes expected
// output bytes into a queue, and a tx monitor decodes and checks them.

module tb_image_processor;
  localparam int CLK_FREQ  = 5_000_000;
  localparam int BAUD_RATE = 1_000_000;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;
  localparam int W         = 8;
  localparam int H         = 8;
  localparam int N         = W * H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b0;
  logic tx;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] img [N];
  logic [7:0] expv [N];

  always #5 clk = ~clk;

  image_processor #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    bit_out(1'b1);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(img[i], 1'b1);
  endtask

  task automatic expect_image();
    for (int i = 0; i < N; i++) exp_q.push_back(expv[i]);
  endtask

  task automatic wait_tx(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 12000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (2 * BIT) @(posedge clk);
    #1;
    check({name, "_state"}, int'(dut.filter.filter_controller.state), 4);
    check({name, "_tx_idle"}, int'(tx), 1);
  endtask

  // tx monitor: centre-samples each frame and pops the scoreboard
  initial begin : tx_monitor
    logic [7:0] b;
    logic [7:0] ev;
    logic sb, pb;
    int nrx;
    nrx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst && tx === 1'b0) begin
        repeat (BIT / 2) @(posedge clk);
        #1;
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (BIT) @(posedge clk);
        #1;
        pb = tx;
        check("tx_start_bit", int'(sb), 0);
        check("tx_stop_bit", int'(pb), 1);
        check("tx_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          $display("tx byte %0d: got %02h expected %02h", nrx, b, ev);
          check("tx_byte", int'(b), int'(ev));
        end
        nrx++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // reset values, with rx held low through reset release
    repeat (5) @(posedge clk);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_state", int'(dut.filter.filter_controller.state), 0);
    check("reset_pix_cnt", int'(dut.pix_cnt_reg), 0);
    rst = 1'b1;
    repeat (6 * BIT) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (12 * BIT) @(posedge clk);
    #1;
    check("rx_low_release_pix_cnt", int'(dut.pix_cnt_reg), 0);
    check("rx_low_release_state", int'(dut.filter.filter_controller.state), 0);

    // uniform 0x80
    for (int i = 0; i < N; i++) begin img[i] = 8'h80; expv[i] = 8'h80; end
    expect_image();
    send_range(0, N - 1);
    wait_tx("uniform");
    check("uniform_ram0", int'(dut.image_ram.ram[0]), 8'h80);
    check("uniform_ram27", int'(dut.image_ram.ram[27]), 8'h80);
    check("uniform_ram63", int'(dut.image_ram.ram[63]), 8'h80);

    // impulse 0xFF at (3,3)
    for (int i = 0; i < N; i++) begin img[i] = 8'h00; expv[i] = 8'h00; end
    img[27] = 8'hFF;
    expv[27] = 8'h3F;
    expv[26] = 8'h1F; expv[28] = 8'h1F; expv[19] = 8'h1F; expv[35] = 8'h1F;
    expv[18] = 8'h0F; expv[20] = 8'h0F; expv[34] = 8'h0F; expv[36] = 8'h0F;
    expect_image();
    send_range(0, N - 1);
    wait_tx("impulse");
    check("impulse_ram27", int'(dut.image_ram.ram[27]), 8'h3F);
    check("impulse_ram35", int'(dut.image_ram.ram[35]), 8'h1F);
    check("impulse_ram18", int'(dut.image_ram.ram[18]), 8'h0F);
    check("impulse_ram45", int'(dut.image_ram.ram[45]), 8'h00);
    check("impulse_inbuf27", int'(dut.input_buf.ram[27]), 8'hFF);

    // corner 0xFF at (0,0)
    for (int i = 0; i < N; i++) begin img[i] = 8'h00; expv[i] = 8'h00; end
    img[0] = 8'hFF;
    expv[0] = 8'hFF;
    expv[9] = 8'h0F;
    expect_image();
    send_range(0, N - 1);
    wait_tx("corner");
    check("corner_ram0", int'(dut.image_ram.ram[0]), 8'hFF);
    check("corner_ram1", int'(dut.image_ram.ram[1]), 8'h00);
    check("corner_ram9", int'(dut.image_ram.ram[9]), 8'h0F);

    // framing error mid-image; ramp p=i is linear so the filter preserves it
    for (int i = 0; i < N; i++) begin img[i] = 8'(i); expv[i] = 8'(i); end
    send_range(0, 19);
    send_byte(8'h55, 1'b0);
    check("framing_pix_cnt", int'(dut.pix_cnt_reg), 20);
    send_range(20, 62);
    check("framing_63_pix_cnt", int'(dut.pix_cnt_reg), 63);
    check("framing_63_state", int'(dut.filter.filter_controller.state), 4);
    expect_image();
    send_range(63, 63);
    wait_tx("framing");

    // reset after 30 bytes, then a full image from address 0
    for (int i = 0; i < 30; i++) send_byte(8'hAA, 1'b1);
    check("pre_reset_pix_cnt", int'(dut.pix_cnt_reg), 30);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_tx", int'(tx), 1);
    check("midreset_state", int'(dut.filter.filter_controller.state), 0);
    check("midreset_pix_cnt", int'(dut.pix_cnt_reg), 0);
    rst = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin img[i] = 8'(255 - i); expv[i] = 8'(255 - i); end
    expect_image();
    send_range(0, N - 1);
    wait_tx("after_reset");
    check("after_reset_ram0", int'(dut.image_ram.ram[0]), 255);

    // gradient rows p = 16*y
    for (int i = 0; i < N; i++) begin img[i] = 8'(16 * (i / W)); expv[i] = 8'(16 * (i / W)); end
    expect_image();
    send_range(0, N - 1);
    wait_tx("gradient");
    check("gradient_ram50", int'(dut.image_ram.ram[50]), 96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
